// File: rtl/writeback_unit_pkg.sv
// Shared definitions for the writeback unit: data/index widths, load funct3
// encodings and the selected-result payload that feeds the writeback register.
package writeback_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REGIDX_W = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned FUNCT3_W = 3;

  // Load funct3 encodings (RV32I)
  localparam logic [FUNCT3_W-1:0] LB  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LH  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LW  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LBU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LHU = 3'b101;

  // Result chosen for writeback this cycle
  typedef struct packed {
    logic [REGIDX_W-1:0] rd;
    logic [XLEN-1:0]     data;
  } wb_payload_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback unit bus bundle: decode issue/hazard, ALU and load result offers,
// regfile write port and the busy scoreboard.
//   slave  : writeback unit view
//   master : decode / execute / load-unit / regfile view
interface writeback_unit_if;
  import writeback_unit_pkg::*;

  logic                issue_valid;
  logic [REGIDX_W-1:0] issue_rd;
  logic                issue_hazard;
  logic [REGIDX_W-1:0] src_a;
  logic [REGIDX_W-1:0] src_b;
  logic                hazard_a;
  logic                hazard_b;
  logic                alu_valid;
  logic [REGIDX_W-1:0] alu_rd;
  logic [XLEN-1:0]     alu_result;
  logic                alu_ready;
  logic                ld_valid;
  logic [REGIDX_W-1:0] ld_rd;
  logic [XLEN-1:0]     ld_data;
  logic [FUNCT3_W-1:0] ld_funct3;
  logic [1:0]          ld_addr_lo;
  logic                ld_ready;
  logic [REGIDX_W-1:0] wb_idx;
  logic [XLEN-1:0]     wb_data;
  logic                wb_enable;
  logic [NUM_REGS-1:0] busy;

  modport slave (
    input  issue_valid, issue_rd, src_a, src_b,
    input  alu_valid, alu_rd, alu_result,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    output issue_hazard, hazard_a, hazard_b, alu_ready, ld_ready,
    output wb_idx, wb_data, wb_enable, busy
  );

  modport master (
    output issue_valid, issue_rd, src_a, src_b,
    output alu_valid, alu_rd, alu_result,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
    input  issue_hazard, hazard_a, hazard_b, alu_ready, ld_ready,
    input  wb_idx, wb_data, wb_enable, busy
  );

endinterface

// File: rtl/writeback_unit_load_align.sv
// load_align: combinational load formatting. Picks the byte/halfword addressed
// by addr_lo out of the raw word and sign- or zero-extends it.
//   data      in  raw 32-bit load word
//   funct3    in  load type (LB/LH/LW/LBU/LHU; others give 0)
//   addr_lo   in  low address bits (bit 0 ignored for halfwords)
//   aligned_c out formatted result
module load_align
  import writeback_unit_pkg::*;
(
  input  logic [XLEN-1:0]     data,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [1:0]          addr_lo,
  output logic [XLEN-1:0]     aligned_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = data[7:0];
    half_sel  = addr_lo[1] ? data[31:16] : data[15:0];
    aligned_c = '0;
    case (addr_lo)
      2'd0:    byte_sel = data[7:0];
      2'd1:    byte_sel = data[15:8];
      2'd2:    byte_sel = data[23:16];
      default: byte_sel = data[31:24];
    endcase
    case (funct3)
      LB:      aligned_c = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     aligned_c = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      aligned_c = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     aligned_c = {{(XLEN-16){1'b0}}, half_sel};
      LW:      aligned_c = data;
      default: aligned_c = '0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU and load results onto a registered regfile
// write port and keeps the busy scoreboard used by decode for hazards.
//   clock, reset  rising-edge clock, async active-high reset
//   bus (slave)   issue/hazard, ALU and load offers, wb_* write port, busy
module writeback_unit
  import writeback_unit_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  writeback_unit_if.slave bus
);

  logic [XLEN-1:0]     ld_aligned_c;
  wb_payload_t         sel_c;
  logic                accept_c;
  logic                issue_hazard_c;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_next_c;
  logic [REGIDX_W-1:0] wb_idx_q;
  logic [XLEN-1:0]     wb_data_q;
  logic                wb_enable_q;

  load_align u_load_align (
    .data      (bus.ld_data),
    .funct3    (bus.ld_funct3),
    .addr_lo   (bus.ld_addr_lo),
    .aligned_c (ld_aligned_c)
  );

  // Hazards look at the current scoreboard only; no bypass from wb_*.
  assign issue_hazard_c = (bus.issue_rd != '0) && busy_q[bus.issue_rd];
  assign bus.issue_hazard = issue_hazard_c;
  assign bus.hazard_a     = (bus.src_a != '0) && busy_q[bus.src_a];
  assign bus.hazard_b     = (bus.src_b != '0) && busy_q[bus.src_b];
  assign bus.alu_ready    = !bus.ld_valid;
  assign bus.ld_ready     = 1'b1;
  assign bus.wb_idx       = wb_idx_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.wb_enable    = wb_enable_q;
  assign bus.busy         = busy_q;

  // Result select (load has priority) and scoreboard next state.
  always_comb begin
    accept_c    = 1'b0;
    sel_c       = '0;
    busy_next_c = busy_q;
    if (bus.ld_valid) begin
      accept_c   = 1'b1;
      sel_c.rd   = bus.ld_rd;
      sel_c.data = ld_aligned_c;
    end else if (bus.alu_valid) begin
      accept_c   = 1'b1;
      sel_c.rd   = bus.alu_rd;
      sel_c.data = bus.alu_result;
    end
    // Clear first so a same-index issue on this edge wins.
    if (wb_enable_q) begin
      busy_next_c[wb_idx_q] = 1'b0;
    end
    if (bus.issue_valid && !issue_hazard_c && (bus.issue_rd != '0)) begin
      busy_next_c[bus.issue_rd] = 1'b1;
    end
    busy_next_c[0] = 1'b0;
  end

  // Writeback register and scoreboard state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_enable_q <= 1'b0;
      wb_idx_q    <= '0;
      wb_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      wb_enable_q <= accept_c && (sel_c.rd != '0);
      if (accept_c) begin
        wb_idx_q  <= sel_c.rd;
        wb_data_q <= sel_c.data;
      end
      busy_q <= busy_next_c;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic
// checked against a behavioural model of the writeback/scoreboard rules.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic clock = 1'b0;
  logic reset;

  writeback_unit_if bus();

  writeback_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit          busy_m[NUM_REGS];
  logic [4:0]  idx_m;
  logic [31:0] data_m;
  bit          en_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_word();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < NUM_REGS; i++) w[i] = busy_m[i];
    return w;
  endfunction

  // Load formatting from the ISA rules using plain arithmetic.
  function automatic logic [31:0] load_ref(input logic [31:0] d, input logic [2:0] f3,
                                           input logic [1:0] lo);
    longint v;
    longint w;
    int unsigned b;
    w = longint'(d);
    b = int'(lo);
    case (f3)
      3'd0: begin v = (w >> (8 * b)) % 256; if (v >= 128) v = v - 256; end
      3'd4: v = (w >> (8 * b)) % 256;
      3'd1: begin v = (w >> (16 * (b / 2))) % 65536; if (v >= 32768) v = v - 65536; end
      3'd5: v = (w >> (16 * (b / 2))) % 65536;
      3'd2: v = w;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) busy_m[i] = 1'b0;
    idx_m  = '0;
    data_m = '0;
    en_m   = 1'b0;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.src_a = '0; bus.src_b = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_result = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.ld_funct3 = '0; bus.ld_addr_lo = '0;
  endtask

  // One cycle: check combinational outputs, predict, clock, check registered outputs.
  task automatic step();
    bit          acc;
    logic [4:0]  rd;
    logic [31:0] val;
    bit          nb[NUM_REGS];
    #1;
    chk("issue_hazard", 32'(bus.issue_hazard),
        32'((bus.issue_rd != 0) && busy_m[bus.issue_rd]));
    chk("hazard_a", 32'(bus.hazard_a), 32'((bus.src_a != 0) && busy_m[bus.src_a]));
    chk("hazard_b", 32'(bus.hazard_b), 32'((bus.src_b != 0) && busy_m[bus.src_b]));
    chk("alu_ready", 32'(bus.alu_ready), 32'(!bus.ld_valid));
    chk("ld_ready", 32'(bus.ld_ready), 32'd1);
    acc = 1'b0; rd = '0; val = '0;
    if (bus.ld_valid) begin
      acc = 1'b1; rd = bus.ld_rd;
      val = load_ref(bus.ld_data, bus.ld_funct3, bus.ld_addr_lo);
    end else if (bus.alu_valid) begin
      acc = 1'b1; rd = bus.alu_rd; val = bus.alu_result;
    end
    nb = busy_m;
    if (en_m) nb[idx_m] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != 0 && !busy_m[bus.issue_rd]) nb[bus.issue_rd] = 1'b1;
    @(posedge clock);
    #1;
    busy_m = nb;
    if (acc) begin idx_m = rd; data_m = val; end
    en_m = acc && (rd != 0);
    chk("wb_enable", 32'(bus.wb_enable), 32'(en_m));
    chk("wb_idx", 32'(bus.wb_idx), 32'(idx_m));
    chk("wb_data", bus.wb_data, data_m);
    chk("busy", bus.busy, busy_word());
  endtask

  // Asynchronous reset away from an edge, then drop results offered during reset.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_wb_enable", 32'(bus.wb_enable), 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_wb_idx", 32'(bus.wb_idx), 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_result = 32'h1234_5678;
    @(posedge clock);
    #1;
    chk("rst_drop_enable", 32'(bus.wb_enable), 32'd0);
    chk("rst_drop_data", bus.wb_data, 32'd0);
    reset = 1'b0;
  endtask

  logic [2:0]  f3_tab[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  lo_tab[5]  = '{2'd1, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] exp_tab[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_8070,
                              32'h0000_FF12, 32'h8070_FF12};
  logic [31:0] busy_before;

  initial begin
    idle();
    model_reset();
    do_reset();
    // First edge after reset deasserts accepts the still-offered result
    step();
    chk("post_rst_accept", 32'(bus.wb_idx), 32'd3);

    // Issue rd=5, hazard on src_a, ALU writes it back, busy clears one edge later
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; step();
    idle(); bus.src_a = 5'd5; bus.alu_valid = 1'b1; bus.alu_rd = 5'd5;
    bus.alu_result = 32'hDEAD_BEEF;
    #1 chk("hazard_a_5", 32'(bus.hazard_a), 32'd1);
    step();
    chk("wb_idx_5", 32'(bus.wb_idx), 32'd5);
    chk("wb_data_beef", bus.wb_data, 32'hDEAD_BEEF);
    chk("busy5_held", 32'(bus.busy[5]), 32'd1);
    idle(); step();
    chk("busy5_clear", 32'(bus.busy[5]), 32'd0);
    chk("wb_enable_drop", 32'(bus.wb_enable), 32'd0);

    // Load and ALU together: load first, ALU held then written
    idle(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd6; bus.ld_funct3 = LW;
    bus.ld_data = 32'h1234_5678;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd8; bus.alu_result = 32'h0000_A5A5;
    step();
    chk("ld_first_idx", 32'(bus.wb_idx), 32'd6);
    bus.ld_valid = 1'b0; step();
    chk("alu_second_idx", 32'(bus.wb_idx), 32'd8);
    chk("alu_second_data", bus.wb_data, 32'h0000_A5A5);

    // Load formats on one word
    for (int i = 0; i < 5; i++) begin
      idle(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 32'h8070_FF12;
      bus.ld_funct3 = f3_tab[i]; bus.ld_addr_lo = lo_tab[i];
      step();
      chk("load_fmt", bus.wb_data, exp_tab[i]);
    end
    idle(); bus.ld_valid = 1'b1; bus.ld_rd = 5'd2; bus.ld_data = 32'h8070_FF12;
    bus.ld_funct3 = 3'b011; step();
    chk("load_bad_f3", bus.wb_data, 32'd0);
    chk("load_bad_f3_en", 32'(bus.wb_enable), 32'd1);

    // rd=0 never writes; set wins over clear on the same index
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_result = 32'hFFFF_0000;
    step();
    chk("rd0_no_write", 32'(bus.wb_enable), 32'd0);
    idle(); bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_result = 32'h77;
    step();
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; step();
    chk("set_wins_7", 32'(bus.busy[7]), 32'd1);

    // Issue onto an already-busy register leaves scoreboard unchanged
    idle(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; step();
    busy_before = bus.busy;
    #1 chk("issue_hazard_9", 32'(bus.issue_hazard), 32'd1);
    step();
    chk("busy_unchanged_9", bus.busy, busy_before);

    // Reset mid-stream with wb_enable high and only busy[4] set
    idle(); do_reset(); idle();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_result = 32'h2222;
    step();
    chk("pre_rst_busy", bus.busy, 32'h0000_0010);
    chk("pre_rst_en", 32'(bus.wb_enable), 32'd1);
    idle(); do_reset(); idle();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      bus.issue_valid = ($urandom_range(0, 1) == 1);
      bus.issue_rd    = 5'($urandom_range(0, 7));
      bus.src_a       = 5'($urandom_range(0, 7));
      bus.src_b       = 5'($urandom_range(0, 7));
      bus.alu_valid   = ($urandom_range(0, 9) < 6);
      bus.alu_rd      = 5'($urandom_range(0, 7));
      bus.alu_result  = $urandom;
      bus.ld_valid    = ($urandom_range(0, 3) == 0);
      bus.ld_rd       = 5'($urandom_range(0, 7));
      bus.ld_data     = $urandom;
      bus.ld_funct3   = 3'($urandom_range(0, 7));
      bus.ld_addr_lo  = 2'($urandom_range(0, 3));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
